// File: rtl/bg_pkg.sv
// Shared types, geometry constants and the 32-entry background palette.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bg_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        BG   = 2'd1,
        P1   = 2'd2,
        P2   = 2'd3
    } scene_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE_OUT,
        ST_SWAP,
        ST_FADE_IN
    } fade_state_t;

    // Per-pixel sideband that travels alongside the ROM access.
    typedef struct packed {
        logic   act;
        scene_t scene;
    } pix_meta_t;

    localparam int BG_W  = 640;
    localparam int SPR_W = 320;
    localparam int ACT_W = 640;
    localparam int ACT_H = 480;

    localparam logic [4:0] BRIGHT_MAX = 5'd16;

    localparam logic [23:0] PALETTE [32] = '{
        24'h000000, 24'h1F3A5C, 24'h2E5E8C, 24'h4A90C8, 24'h7EC0EE, 24'hB0E0FF, 24'h103010, 24'hFFFFFF,
        24'h2F6F2F, 24'h4FA04F, 24'h80D080, 24'hC0F0C0, 24'h402010, 24'h704020, 24'hA06030, 24'hD09050,
        24'hF0C080, 24'h600000, 24'hA00000, 24'hE03030, 24'hFF8080, 24'h303030, 24'h606060, 24'h909090,
        24'hC0C0C0, 24'hE0E0E0, 24'hFFD700, 24'hFFA500, 24'h8A2BE2, 24'h4B0082, 24'h00CED1, 24'h123456
    };

    // One colour channel scaled by brightness/16; brightness 16 is unity gain.
    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [4:0] bright);
        logic [12:0] prod;
        prod = 13'(ch) * 13'(bright);
        return 8'(prod >> 4);
    endfunction

endpackage

// File: rtl/bg_fade_ctrl.sv
// Scene selection FSM with per-frame fade-out / swap / fade-in brightness sequencing.
// Latency: scene and brightness update on the frame_start cycle; busy rises the cycle after acceptance.
// Backpressure: none; requests arriving while busy are dropped, not queued.
module bg_fade_ctrl
    import bg_pkg::*;
#(
    parameter logic [1:0] RESET_SCENE = 2'd1,
    parameter logic [4:0] FADE_STEP   = 5'd2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_start,
    input  logic [1:0] i_scene_req,
    input  logic       i_scene_req_vld,
    output scene_t     o_scene,
    output logic [4:0] o_brightness,
    output logic       o_scene_busy
);

    fade_state_t r_state, w_state_nxt;
    logic [4:0]  r_bright, w_bright_nxt;
    scene_t      r_scene, w_scene_nxt;
    scene_t      r_pending, w_pending_nxt;

    logic [5:0]  w_up;
    logic        w_out_done;

    assign w_up       = {1'b0, r_bright} + {1'b0, FADE_STEP};
    assign w_out_done = (r_bright <= FADE_STEP);

    // Next-state: one brightness step or scene swap per frame_start while a change is in flight.
    always_comb begin
        w_state_nxt   = r_state;
        w_bright_nxt  = r_bright;
        w_scene_nxt   = r_scene;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (i_scene_req_vld && (scene_t'(i_scene_req) != r_scene)) begin
                    w_pending_nxt = scene_t'(i_scene_req);
                    w_state_nxt   = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                if (i_frame_start) begin
                    if (w_out_done) begin
                        w_bright_nxt = '0;
                        w_state_nxt  = ST_SWAP;
                    end else begin
                        w_bright_nxt = r_bright - FADE_STEP;
                    end
                end
            end
            ST_SWAP: begin
                if (i_frame_start) begin
                    w_scene_nxt = r_pending;
                    w_state_nxt = ST_FADE_IN;
                end
            end
            ST_FADE_IN: begin
                if (i_frame_start) begin
                    if (w_up >= 6'(BRIGHT_MAX)) begin
                        w_bright_nxt = BRIGHT_MAX;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_bright_nxt = w_up[4:0];
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops any pending request and restores full brightness.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bright  <= BRIGHT_MAX;
            r_scene   <= scene_t'(RESET_SCENE);
            r_pending <= NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_bright  <= w_bright_nxt;
            r_scene   <= w_scene_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // The scene handed out is the one in force for the pixel sampled this cycle, so the
    // frame_start pixel of a swap frame already belongs to the new scene.
    assign o_scene      = w_scene_nxt;
    assign o_brightness = r_bright;
    assign o_scene_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/bg_pixel_fetch.sv
// Background fetch: DrawX/DrawY -> ROM address + scene, palette index -> faded 24-bit RGB.
// Latency: address/is_bg 1 cycle, RGB/rgb_valid 3 cycles after DrawX/DrawY.
// Backpressure: none; free-running pixel pipeline advancing every Clk.
module bg_pixel_fetch
    import bg_pkg::*;
#(
    parameter logic [1:0] RESET_SCENE = 2'd1,
    parameter logic [4:0] FADE_STEP   = 5'd2,
    parameter int         ROM_LAT     = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic [1:0]  scene_req,
    input  logic        scene_req_valid,
    output logic        scene_busy,
    output logic [18:0] bg_read_address,
    output logic [1:0]  is_bg,
    input  logic [4:0]  bg_data_in,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        rgb_valid
);

    scene_t     w_scene;
    logic [4:0] w_bright;
    logic       w_active;
    logic [8:0] w_y2;
    logic [18:0] w_addr;

    logic [18:0] r_addr;
    pix_meta_t   r_s1;
    pix_meta_t   r_s2 [ROM_LAT];
    pix_meta_t   w_s2;
    logic [23:0] w_pal;
    logic [23:0] w_rgb;
    logic [23:0] r_rgb;
    logic        r_rgb_vld;

    bg_fade_ctrl #(
        .RESET_SCENE (RESET_SCENE),
        .FADE_STEP   (FADE_STEP)
    ) u_fade (
        .i_clk           (Clk),
        .i_rst           (Reset),
        .i_frame_start   (frame_start),
        .i_scene_req     (scene_req),
        .i_scene_req_vld (scene_req_valid),
        .o_scene         (w_scene),
        .o_brightness    (w_bright),
        .o_scene_busy    (scene_busy)
    );

    assign w_y2     = DrawY[9:1];
    assign w_active = (DrawX < 10'(ACT_W)) && (DrawY < 10'(ACT_H));

    // Address generation: full-width background or half-resolution 320-wide picture.
    always_comb begin
        w_addr = '0;
        if (w_active) begin
            case (w_scene)
                BG:      w_addr = 19'(w_y2) * 19'(BG_W) + 19'(DrawX);
                P1, P2:  w_addr = 19'(w_y2) * 19'(SPR_W) + 19'(DrawX[9:1]);
                default: w_addr = '0;
            endcase
        end
    end

    // S1: ROM address and the sideband that must stay aligned with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr <= '0;
            r_s1   <= '{act: 1'b0, scene: scene_t'(RESET_SCENE)};
        end else begin
            r_addr <= w_addr;
            r_s1   <= '{act: w_active, scene: w_scene};
        end
    end

    // S2: delay the sideband by the ROM read latency so it meets bg_data_in.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_s2[i] <= '{act: 1'b0, scene: scene_t'(RESET_SCENE)};
            end
        end else begin
            r_s2[0] <= r_s1;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_s2[i] <= r_s2[i-1];
            end
        end
    end

    assign w_s2 = r_s2[ROM_LAT-1];

    // S3 datapath: palette lookup then brightness scale; blank for scene NONE or blanking.
    always_comb begin
        w_pal = PALETTE[bg_data_in];
        w_rgb = '0;
        if (w_s2.act && (w_s2.scene != NONE)) begin
            w_rgb = {scale_ch(w_pal[23:16], w_bright),
                     scale_ch(w_pal[15:8],  w_bright),
                     scale_ch(w_pal[7:0],   w_bright)};
        end
    end

    // S3: register the output colour and its active-pixel flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rgb     <= '0;
            r_rgb_vld <= 1'b0;
        end else begin
            r_rgb     <= w_rgb;
            r_rgb_vld <= w_s2.act;
        end
    end

    assign bg_read_address = r_addr;
    assign is_bg           = r_s1.scene;
    assign red             = r_rgb[23:16];
    assign green           = r_rgb[15:8];
    assign blue            = r_rgb[7:0];
    assign rgb_valid       = r_rgb_vld;

endmodule

// File: tb/tb_bg_pixel_fetch.sv
// Scoreboard bench for bg_pixel_fetch: random pixels, scene fades, reset mid-fade.
module tb_bg_pixel_fetch;
    import bg_pkg::*;

    localparam int STEP  = 2;
    localparam int N_OUT = (16 + STEP - 1) / STEP;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_start;
    logic [1:0]  scene_req;
    logic        scene_req_valid;
    logic        scene_busy;
    logic [18:0] bg_read_address;
    logic [1:0]  is_bg;
    logic [4:0]  bg_data_in;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        rgb_valid;

    bg_pixel_fetch #(
        .RESET_SCENE (2'd1),
        .FADE_STEP   (5'd2),
        .ROM_LAT     (1)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .frame_start     (frame_start),
        .scene_req       (scene_req),
        .scene_req_valid (scene_req_valid),
        .scene_busy      (scene_busy),
        .bg_read_address (bg_read_address),
        .is_bg           (is_bg),
        .bg_data_in      (bg_data_in),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .rgb_valid       (rgb_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM contents: address 645 holds index 7, everything else a simple hash.
    function automatic logic [4:0] rom_idx(input int a);
        if (a == 645) return 5'd7;
        return 5'((a * 13 + (a >>> 4)) % 32);
    endfunction

    always @(posedge Clk) bg_data_in <= rom_idx(int'(bg_read_address));

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model of scene/brightness as a function of frames since acceptance.
    int m_scene   = 1;
    int m_bright  = 16;
    int m_busy    = 0;
    int m_pending = 0;
    int m_k       = 0;

    task automatic model_req(input int rq);
        if (rq != m_scene) begin
            m_busy = 1; m_pending = rq; m_k = 0;
        end
    endtask

    task automatic model_frame();
        m_k++;
        if (m_k <= N_OUT) begin
            m_bright = (16 - STEP * m_k < 0) ? 0 : 16 - STEP * m_k;
        end else if (m_k == N_OUT + 1) begin
            m_scene = m_pending; m_bright = 0;
        end else begin
            m_bright = (STEP * (m_k - N_OUT - 1) > 16) ? 16 : STEP * (m_k - N_OUT - 1);
            if (m_bright == 16) m_busy = 0;
        end
    endtask

    function automatic int exp_addr(input int x, input int y, input int sc);
        if (x >= 640 || y >= 480 || sc == 0) return 0;
        if (sc == 1) return (y / 2) * 640 + x;
        return (y / 2) * 320 + x / 2;
    endfunction

    function automatic int exp_rgb(input int a, input bit act, input int sc, input int b);
        int p, r, g, bl;
        if (!act || sc == 0) return 0;
        p  = int'(PALETTE[rom_idx(a)]);
        r  = ((((p >> 16) & 255) * b) / 16) & 255;
        g  = ((((p >> 8) & 255) * b) / 16) & 255;
        bl = (((p & 255) * b) / 16) & 255;
        return (r << 16) | (g << 8) | bl;
    endfunction

    typedef struct { int due; int addr; int scene; int busy; } s1_exp_t;
    typedef struct { int due; int rgb; int vld; string tag; } s3_exp_t;
    s1_exp_t q1[$];
    s3_exp_t q3[$];
    int      qr[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic cmp(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic missed(input string name, input int due);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected output at cycle %0d never checked (now %0d)", name, due, cyc);
    endtask

    // Monitor: pop every expectation whose due cycle has arrived and compare.
    always @(negedge Clk) begin
        s1_exp_t e1;
        s3_exp_t e3;
        while (q1.size() > 0 && q1[0].due < cyc) begin e1 = q1.pop_front(); missed("s1", e1.due); end
        while (q3.size() > 0 && q3[0].due < cyc) begin e3 = q3.pop_front(); missed("s3", e3.due); end
        while (qr.size() > 0 && qr[0] < cyc)     begin missed("reset", qr.pop_front()); end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e1 = q1.pop_front();
            cmp("address", int'(bg_read_address), e1.addr);
            cmp("is_bg", int'(is_bg), e1.scene);
            cmp("scene_busy", int'(scene_busy), e1.busy);
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e3 = q3.pop_front();
            cmp({e3.tag, "_rgb"}, int'({red, green, blue}), e3.rgb);
            cmp({e3.tag, "_rgb_valid"}, int'(rgb_valid), e3.vld);
        end
        if (qr.size() > 0 && qr[0] == cyc) begin
            void'(qr.pop_front());
            cmp("reset_address", int'(bg_read_address), 0);
            cmp("reset_is_bg", int'(is_bg), 1);
            cmp("reset_rgb", int'({red, green, blue}), 0);
            cmp("reset_rgb_valid", int'(rgb_valid), 0);
            cmp("reset_busy", int'(scene_busy), 0);
        end
    end

    // Present one pixel (plus optional strobes) for one cycle, pushing expectations if chk.
    task automatic drive(input int x, input int y, input bit fs, input bit rv, input int rq, input bit chk);
        int a;
        bit act;
        DrawX = 10'(x); DrawY = 10'(y);
        frame_start = fs; scene_req = 2'(rq); scene_req_valid = rv;
        if (m_busy == 0) begin
            if (rv) model_req(rq);
        end else if (fs) begin
            model_frame();
        end
        if (chk) begin
            act = (x < 640) && (y < 480);
            a   = exp_addr(x, y, m_scene);
            q1.push_back('{cyc + 1, a, m_scene, m_busy});
            q3.push_back('{cyc + 3, exp_rgb(a, act, m_scene, m_bright), int'(act), "pix"});
        end
        @(posedge Clk); #1;
        frame_start = 1'b0;
        scene_req_valid = 1'b0;
    endtask

    task automatic random_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            drive(int'($urandom_range(799, 0)), int'($urandom_range(524, 0)), 1'b0, 1'b0, 0, 1'b1);
        end
    endtask

    // Blanking lead-in, the frame_start pixel, then two active pixels of the new frame.
    task automatic frame_pulse();
        drive(700, 500, 1'b0, 1'b0, 0, 1'b0);
        drive(700, 500, 1'b0, 1'b0, 0, 1'b0);
        drive(0, 0, 1'b1, 1'b0, 0, 1'b1);
        drive(5, 3, 1'b0, 1'b0, 0, 1'b1);
        drive(int'($urandom_range(639, 0)), int'($urandom_range(479, 0)), 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic run_fade();
        for (int i = 0; i < 40 && m_busy != 0; i++) frame_pulse();
    endtask

    initial begin
        Reset = 1'b1; DrawX = '0; DrawY = '0; frame_start = 1'b0;
        scene_req = '0; scene_req_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        qr.push_back(cyc);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Scene 1 (640x240 background)
        drive(5, 3, 1'b0, 1'b0, 0, 1'b1);
        drive(639, 479, 1'b0, 1'b0, 0, 1'b1);
        drive(640, 100, 1'b0, 1'b0, 0, 1'b1);
        drive(100, 480, 1'b0, 1'b0, 0, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 0, 1'b1);
        random_pixels(30);

        // Fade to scene 2; mid-fade request is dropped; brightness 8 halves a 0xFF channel
        drive(5, 3, 1'b0, 1'b1, 2, 1'b1);
        for (int i = 0; i < 40 && m_busy != 0; i++) begin
            frame_pulse();
            if (m_k == 2) drive(5, 3, 1'b0, 1'b1, 3, 1'b1);
            if (m_k == 4) begin
                q3.push_back('{cyc + 3, 32'h7F7F7F, 1, "half_bright"});
                drive(5, 3, 1'b0, 1'b0, 0, 1'b0);
            end
        end

        // Scene 2 (320x240 picture)
        drive(639, 479, 1'b0, 1'b0, 0, 1'b1);
        drive(640, 479, 1'b0, 1'b0, 0, 1'b1);
        drive(1, 1, 1'b0, 1'b0, 0, 1'b1);
        random_pixels(30);

        // Same-scene request is ignored
        drive(10, 10, 1'b0, 1'b1, 2, 1'b1);
        drive(11, 10, 1'b0, 1'b0, 0, 1'b1);

        // Request on the frame_start cycle while idle: accepted, no decrement that frame
        drive(0, 0, 1'b1, 1'b1, 3, 1'b1);
        drive(5, 3, 1'b0, 1'b0, 0, 1'b1);
        run_fade();
        random_pixels(15);

        // Pending scene 0: fade runs normally, picture stays black
        drive(5, 3, 1'b0, 1'b1, 0, 1'b1);
        run_fade();
        random_pixels(10);

        // Reset in the middle of a fade-out
        drive(5, 3, 1'b0, 1'b1, 1, 1'b1);
        frame_pulse();
        frame_pulse();
        frame_pulse();
        repeat (4) drive(5, 3, 1'b0, 1'b0, 0, 1'b0);
        Reset = 1'b1;
        qr.push_back(cyc);
        @(posedge Clk); #1;
        Reset = 1'b0;
        m_scene = 1; m_bright = 16; m_busy = 0; m_pending = 0; m_k = 0;
        drive(5, 3, 1'b0, 1'b0, 0, 1'b1);
        random_pixels(10);

        repeat (6) drive(700, 500, 1'b0, 1'b0, 0, 1'b0);
        if (q1.size() != 0 || q3.size() != 0 || qr.size() != 0) begin
            $display("FAIL drain: %0d expectations still queued", q1.size() + q3.size() + qr.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
